// File: rtl/fetch_seq.sv
// Instruction sequencer: PC, conditional abs/rel branches, call/return stack, halt, saturating counters.
// Every decision is registered and visible after the deciding edge; stall holds PC and stack while cycle_ct still runs.
module fetch_seq #(
   parameter int              PW         = 10,
   parameter int              OFS_W      = 6,
   parameter int              DEPTH      = 4,
   parameter int              CW         = 16,
   parameter logic [PW-1:0]   START_ADDR = '0
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic             stall,
   input  logic             branch_en,
   input  logic             branch_cond,
   input  logic             branch_rel,
   input  logic             flag_in,
   input  logic [PW-1:0]    target,
   input  logic [OFS_W-1:0] offset,
   input  logic             call_en,
   input  logic             ret_en,
   input  logic             halt_req,
   output logic [PW-1:0]    PC,
   output logic             halt,
   output logic [CW-1:0]    cycle_ct,
   output logic [CW-1:0]    inst_ct,
   output logic             stack_ovf,
   output logic             stack_unf
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]  stk [DEPTH];
   logic [SPW-1:0] sp;
   logic [PW-1:0]  pc_inc;
   logic [PW-1:0]  ofs_ext;
   logic [PW-1:0]  br_pc;
   logic [AW-1:0]  push_idx;
   logic [AW-1:0]  top_idx;
   logic           taken;
   logic           stk_full;
   logic           stk_empty;
   logic           active;
   logic           push;

   always_comb begin
      pc_inc    = PC + PW'(1);
      ofs_ext   = {{(PW-OFS_W){offset[OFS_W-1]}}, offset};
      taken     = !branch_cond || flag_in;
      br_pc     = !taken ? pc_inc : (branch_rel ? PC + ofs_ext : target);
      stk_full  = (sp == SPW'(DEPTH));
      stk_empty = (sp == '0);
      push_idx  = AW'(sp);
      top_idx   = AW'(sp - SPW'(1));
      active    = !start && !halt && !stall;
      push      = active && !halt_req && !ret_en && call_en && !stk_full;
   end

   // Entries need no reset: the depth counter alone defines which are valid.
   always_ff @(posedge CLK) begin
      if (push)
         stk[push_idx] <= pc_inc;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         PC        <= START_ADDR;
         halt      <= 1'b0;
         cycle_ct  <= '0;
         inst_ct   <= '0;
         sp        <= '0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
      end else if (start) begin
         PC        <= START_ADDR;
         halt      <= 1'b0;
         cycle_ct  <= '0;
         inst_ct   <= '0;
         sp        <= '0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
      end else if (!halt) begin
         if (cycle_ct != '1)
            cycle_ct <= cycle_ct + CW'(1);
         if (!stall) begin
            // The halting instruction itself retires, including stack errors.
            if (inst_ct != '1)
               inst_ct <= inst_ct + CW'(1);
            if (halt_req) begin
               halt <= 1'b1;
            end else if (ret_en) begin
               if (stk_empty) begin
                  stack_unf <= 1'b1;
                  halt      <= 1'b1;
               end else begin
                  PC <= stk[top_idx];
                  sp <= sp - SPW'(1);
               end
            end else if (call_en) begin
               if (stk_full) begin
                  stack_ovf <= 1'b1;
                  halt      <= 1'b1;
               end else begin
                  PC <= target;
                  sp <= sp + SPW'(1);
               end
            end else if (branch_en) begin
               PC <= br_pc;
            end else begin
               PC <= pc_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; a second instance with CW=4 shares the stimulus to exercise counter saturation.
module tb_fetch_seq;

   logic        CLK = 1'b0;
   logic        reset;
   logic        start, stall, branch_en, branch_cond, branch_rel, flag_in;
   logic [9:0]  target;
   logic [5:0]  offset;
   logic        call_en, ret_en, halt_req;

   logic [9:0]  PC,  PC2;
   logic        halt, halt2, ovf, ovf2, unf, unf2;
   logic [15:0] cyc, inst;
   logic [3:0]  cyc2, inst2;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_seq dut (
      .CLK(CLK), .reset(reset), .start(start), .stall(stall),
      .branch_en(branch_en), .branch_cond(branch_cond), .branch_rel(branch_rel),
      .flag_in(flag_in), .target(target), .offset(offset),
      .call_en(call_en), .ret_en(ret_en), .halt_req(halt_req),
      .PC(PC), .halt(halt), .cycle_ct(cyc), .inst_ct(inst),
      .stack_ovf(ovf), .stack_unf(unf)
   );

   fetch_seq #(.CW(4)) dut_sat (
      .CLK(CLK), .reset(reset), .start(start), .stall(stall),
      .branch_en(branch_en), .branch_cond(branch_cond), .branch_rel(branch_rel),
      .flag_in(flag_in), .target(target), .offset(offset),
      .call_en(call_en), .ret_en(ret_en), .halt_req(halt_req),
      .PC(PC2), .halt(halt2), .cycle_ct(cyc2), .inst_ct(inst2),
      .stack_ovf(ovf2), .stack_unf(unf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      start = 0; stall = 0; branch_en = 0; branch_cond = 0; branch_rel = 0;
      flag_in = 0; target = '0; offset = '0; call_en = 0; ret_en = 0; halt_req = 0;
   endtask

   task automatic do_start();
      idle(); start = 1; tick(); start = 0;
   endtask

   task automatic jump(input logic [9:0] t);
      idle(); branch_en = 1; target = t; tick(); idle();
   endtask

   task automatic call(input logic [9:0] t);
      idle(); call_en = 1; target = t; tick(); idle();
   endtask

   task automatic ret();
      idle(); ret_en = 1; tick(); idle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      chk("rst_pc",   PC,   0);
      chk("rst_halt", halt, 0);
      chk("rst_cyc",  cyc,  0);
      chk("rst_inst", inst, 0);
      chk("rst_ovf",  ovf,  0);
      chk("rst_unf",  unf,  0);
      reset = 1'b1;

      // 1: free running after start
      do_start();
      chk("start_pc", PC, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("seq_pc", PC, i);
      end
      chk("seq_cyc",  cyc,  5);
      chk("seq_inst", inst, 5);
      chk("seq_halt", halt, 0);

      // 2: branches
      jump(10'd8);
      chk("abs_pc", PC, 8);
      branch_en = 1; branch_rel = 1; branch_cond = 1; flag_in = 1; offset = 6'b111100;
      tick(); idle();
      chk("rel_taken", PC, 4);
      jump(10'd8);
      branch_en = 1; branch_rel = 1; branch_cond = 1; flag_in = 0; offset = 6'b111100;
      tick(); idle();
      chk("rel_not_taken", PC, 9);
      jump(10'd1022);
      branch_en = 1; branch_rel = 1; offset = 6'd3;
      tick(); idle();
      chk("rel_wrap", PC, 1);
      jump(10'd1023);
      tick();
      chk("seq_wrap", PC, 0);

      // 3: stack overflow, then LIFO unwind
      do_start();
      jump(10'd10);
      call(10'd100); chk("call1", PC, 100);
      call(10'd200);
      call(10'd300);
      call(10'd400); chk("call4", PC, 400);
      call(10'd500);
      chk("ovf_flag", ovf, 1);
      chk("ovf_halt", halt, 1);
      chk("ovf_pc",   PC, 400);
      chk("ovf_cyc",  cyc, 6);
      chk("ovf_inst", inst, 6);
      call(10'd600);
      chk("ovf_frozen_pc",  PC, 400);
      chk("ovf_frozen_cyc", cyc, 6);
      do_start();
      chk("ovf_cleared", ovf, 0);
      jump(10'd10);
      call(10'd100); call(10'd200); call(10'd300); call(10'd400);
      ret(); chk("ret1", PC, 301);
      ret(); chk("ret2", PC, 201);
      ret(); chk("ret3", PC, 101);
      ret(); chk("ret4", PC, 11);
      chk("unwind_halt", halt, 0);

      // 4: underflow
      do_start();
      jump(10'd20);
      ret();
      chk("unf_flag", unf, 1);
      chk("unf_halt", halt, 1);
      chk("unf_pc",   PC, 20);
      tick(); tick();
      chk("unf_cyc",  cyc, 2);
      chk("unf_inst", inst, 2);
      do_start();
      chk("unf_clr",      unf, 0);
      chk("unf_clr_halt", halt, 0);
      chk("unf_clr_pc",   PC, 0);
      chk("unf_clr_cyc",  cyc, 0);

      // 5: stall, then halt_req beats call_en
      jump(10'd7);
      stall = 1; branch_en = 1; target = 10'd50;
      tick(); tick(); tick(); idle();
      chk("stall_pc",   PC, 7);
      chk("stall_cyc",  cyc, 4);
      chk("stall_inst", inst, 1);
      halt_req = 1; call_en = 1; target = 10'd100;
      tick(); idle();
      chk("hreq_halt", halt, 1);
      chk("hreq_pc",   PC, 7);
      chk("hreq_cyc",  cyc, 5);
      chk("hreq_inst", inst, 2);
      chk("hreq_ovf",  ovf, 0);

      // 6: saturation on the CW=4 instance, then async reset
      do_start();
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cyc",  cyc2,  15);
      chk("sat_inst", inst2, 15);
      chk("wide_cyc", cyc,   20);
      chk("sat_pc",   PC2,   20);
      #3 reset = 1'b0;
      #1;
      chk("arst_pc",   PC2,   0);
      chk("arst_cyc",  cyc2,  0);
      chk("arst_inst", inst2, 0);
      chk("arst_pc_w", PC,    0);
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised instruction sequencer for the ACDC core family. Owns the program counter, conditional absolute/relative branching, a hardware call/return stack, and halt handling.
- Also provides saturating cycle and retired-instruction counters.
- Sits between Ctrl (branch/call/halt decodes) and InstROM (drives InstAddress). Replaces ad-hoc PC and cycle_ct logic in the top level.

Parameters:
PW, 10, program counter width; address space 2^PW words
OFS_W, 6, width of signed relative branch offset
DEPTH, 4, call/return stack entries (>=1)
CW, 16, width of cycle and instruction counters
START_ADDR, 0, PC value loaded on reset and start

Ports:
CLK  input  1  clock, posedge
reset  input  1  asynchronous, active-low reset
start  input  1  synchronous init, active-high
stall  input  1  hold PC this cycle (no retire)
branch_en  input  1  branch instruction present
branch_cond  input  1  1 = branch taken only if flag_in = 1; 0 = unconditional
branch_rel  input  1  1 = relative (offset), 0 = absolute (target)
flag_in  input  1  condition flag from ALU flag register
target  input  PW  absolute branch/call target
offset  input  OFS_W  signed relative branch offset
call_en  input  1  call to target
ret_en  input  1  return to top-of-stack
halt_req  input  1  halt instruction present
PC  output  PW  current instruction address
halt  output  1  core halted
cycle_ct  output  CW  cycles since start while not halted
inst_ct  output  CW  retired instructions
stack_ovf  output  1  sticky: call with stack full
stack_unf  output  1  sticky: return with stack empty

Behaviour:
- Reset (reset=0, asynchronous): PC=START_ADDR; halt=0; cycle_ct=0; inst_ct=0; stack empty; stack_ovf=0; stack_unf=0.
- All outputs are registered. Every decision taken in cycle N is visible after posedge N.
- Priority per posedge: start > halted > stall > halt_req > ret_en > call_en > branch_en > sequential.
- start=1: same state as reset. No counting in that cycle.
- Halted (halt=1): all state frozen, including counters, until start or reset. Other inputs are ignored.
- stall=1 (not halted): PC and stack held; inst_ct held; cycle_ct increments.
- halt_req: halt=1 next cycle; PC held at the halt instruction's address; inst_ct increments (halt retires); cycle_ct increments.
- ret_en:
  - Stack non-empty: PC <= top entry; pop.
  - Stack empty: stack_unf=1, halt=1, PC held.
- call_en:
  - Stack not full: push PC+1 (mod 2^PW); PC <= target.
  - Stack full: stack_ovf=1, halt=1, PC held, stack unchanged.
- branch_en, taken when branch_cond=0 or flag_in=1:
  - branch_rel=1: PC <= PC + sign_extend(offset), mod 2^PW.
  - branch_rel=0: PC <= target.
  - Not taken: PC <= PC+1.
- Sequential: PC <= PC+1 mod 2^PW. PC = 2^PW-1 wraps to 0 without error.
- Simultaneous enables resolve by the priority order above; lower-priority enables are ignored that cycle.
- Counters:
  - cycle_ct increments on every non-start, non-halted posedge, including stall cycles.
  - inst_ct increments on every non-start, non-halted, non-stalled posedge, including the cycle that sets halt via halt_req or a stack error.
  - Both counters saturate at 2^CW-1 and never wrap.
- Stack is LIFO of DEPTH entries, each PW bits, with depth counter 0..DEPTH. Exactly one push or pop per cycle.
- stack_ovf and stack_unf are sticky; cleared only by reset or start.
- Reset asserted mid-operation clears state immediately, independent of CLK. Deassertion is synchronised externally.

Test Plan:
1. Reset, then start=1 for 1 cycle, 5 free-running cycles -> PC 0,1,2,3,4,5; cycle_ct=5; inst_ct=5; halt=0.
2. PC=8, branch_en=1, branch_rel=1, branch_cond=1, flag_in=1, offset=6'b111100 (-4) -> PC=4 next. Same with flag_in=0 -> PC=9. Relative +3 from PC=1022 (PW=10) -> PC=1 (wrap).
3. DEPTH=4: call to 100 from PC=10, then 3 further calls, then a 5th call -> stack_ovf=1, halt=1, PC held at 5th call address. After start, 4 calls then 4 returns -> PCs 11, etc. unwind in LIFO order.
4. ret_en with empty stack at PC=20 -> stack_unf=1, halt=1, PC=20. Further cycles: counters frozen; start clears all.
5. stall high for 3 cycles at PC=7 -> PC stays 7, cycle_ct +3, inst_ct +0. Then halt_req and call_en together -> halt=1, no push, PC=7.
6. CW=4, run 20 cycles -> cycle_ct=15 and inst_ct=15 (saturated). Assert reset=0 asynchronously between clock edges -> PC=START_ADDR and counters 0 before the next edge.
